// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the CPU DataPath.
// A three-step fetch (T0-T2) is followed by opcode-dependent execute
// steps (T3-T7). All strobes are a decode of the registered state and IR[31:27].
module control_unit (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic [4:0]  operation,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        OutPortin,
  output logic        Cout,
  output logic        CONin
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state;
  logic       stop_flag;
  logic       stop_pending;
  logic [4:0] opcode;
  logic       is_alu;
  logic       is_imm;
  logic       is_mem;
  logic       is_muldiv;
  logic       is_negnot;

  assign opcode       = IR[31:27];
  assign stop_pending = stop_flag | Stop;
  assign is_alu       = (opcode >= OP_ADD) && (opcode <= OP_SHL);
  assign is_imm       = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
  assign is_mem       = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
  assign is_muldiv    = (opcode == OP_DIV) || (opcode == OP_MUL);
  assign is_negnot    = (opcode == OP_NEG) || (opcode == OP_NOT);

  // Final control step of each instruction class; nop, undefined and halt end at T2.
  function automatic state_t last_step(input logic [4:0] op);
    state_t s;
    case (op)
      OP_LD, OP_ST:                          s = S_T7;
      OP_DIV, OP_MUL, OP_BR:                 s = S_T6;
      OP_LDI, OP_ADDI, 5'b01101, OP_ORI:     s = S_T5;
      OP_NEG, OP_NOT:                        s = S_T4;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: s = S_T3;
      default: begin
        if ((op >= OP_ADD) && (op <= OP_SHL)) begin
          s = S_T5;
        end else begin
          s = S_T2;
        end
      end
    endcase
    return s;
  endfunction

  // State sequencing and sticky Stop capture; an instruction boundary with a
  // pending Stop diverts to HALT, which only clear can leave.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state     <= S_RESET;
      stop_flag <= 1'b0;
    end else begin
      if (Stop) begin
        stop_flag <= 1'b1;
      end
      case (state)
        S_RESET: state <= stop_pending ? S_HALT : S_T0;
        S_HALT:  state <= S_HALT;
        default: begin
          if ((state == S_T2) && (opcode == OP_HALT)) begin
            state <= S_HALT;
          end else if (state == last_step(opcode)) begin
            state <= stop_pending ? S_HALT : S_T0;
          end else begin
            state <= state_t'(state + 4'd1);
          end
        end
      endcase
    end
  end

  // Moore decode of the current step into DataPath strobes and ALU select.
  always_comb begin
    Run       = (state != S_RESET) && (state != S_HALT);
    operation = 5'b00000;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; Read = 1'b0; Write = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    Zhighout = 1'b0; Zlowout = 1'b0; HIin = 1'b0; LOin = 1'b0; HIout = 1'b0;
    LOout = 1'b0; InPortout = 1'b0; OutPortin = 1'b0; Cout = 1'b0; CONin = 1'b0;
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        if (is_alu || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_negnot) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode;
        end else begin
          case (opcode)
            OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode;
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1; operation = opcode;
        end else if (is_mem) begin
          Cout = 1'b1; Zin = 1'b1; operation = OP_ADD;
        end else if (is_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode;
        end else if (is_negnot) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (opcode == OP_BR) begin
          PCout = 1'b1; Yin = 1'b1;
        end else begin
          operation = 5'b00000;
        end
      end
      S_T5: begin
        if (is_alu || is_imm || (opcode == OP_LDI)) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if ((opcode == OP_LD) || (opcode == OP_ST)) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if (opcode == OP_BR) begin
          Cout = 1'b1; Zin = 1'b1; operation = OP_ADD;
        end else begin
          operation = 5'b00000;
        end
      end
      S_T6: begin
        if (opcode == OP_LD) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (opcode == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (is_muldiv) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end else if (opcode == OP_BR) begin
          Zlowout = 1'b1; PCin = CON_FF;
        end else begin
          operation = 5'b00000;
        end
      end
      S_T7: begin
        if (opcode == OP_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (opcode == OP_ST) begin
          Write = 1'b1;
        end else begin
          operation = 5'b00000;
        end
      end
      default: operation = 5'b00000;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-step expected control vectors are
// queued from an opcode table and compared on every falling clock edge.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] IR = 32'd0;
  logic        CON_FF = 1'b0;
  logic        Stop = 1'b0;
  logic        Run;
  logic [4:0]  operation;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin;
  logic MDRout, Read, Write, IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin;
  logic HIout, LOout, InPortout, OutPortin, Cout, CONin;

  int checks = 0;
  int failures = 0;
  logic [32:0] sb[$];
  logic [32:0] seq[$];
  logic [32:0] obs;

  localparam logic [32:0] RUN  = 33'd1 << 32;
  localparam logic [32:0] GRA  = 33'd1 << 26;
  localparam logic [32:0] GRB  = 33'd1 << 25;
  localparam logic [32:0] GRC  = 33'd1 << 24;
  localparam logic [32:0] RIN  = 33'd1 << 23;
  localparam logic [32:0] ROUT = 33'd1 << 22;
  localparam logic [32:0] BAO  = 33'd1 << 21;
  localparam logic [32:0] PCO  = 33'd1 << 20;
  localparam logic [32:0] PCI  = 33'd1 << 19;
  localparam logic [32:0] INC  = 33'd1 << 18;
  localparam logic [32:0] MARI = 33'd1 << 17;
  localparam logic [32:0] MDRI = 33'd1 << 16;
  localparam logic [32:0] MDRO = 33'd1 << 15;
  localparam logic [32:0] RD   = 33'd1 << 14;
  localparam logic [32:0] WR   = 33'd1 << 13;
  localparam logic [32:0] IRI  = 33'd1 << 12;
  localparam logic [32:0] YI   = 33'd1 << 11;
  localparam logic [32:0] ZI   = 33'd1 << 10;
  localparam logic [32:0] ZHO  = 33'd1 << 9;
  localparam logic [32:0] ZLO  = 33'd1 << 8;
  localparam logic [32:0] HII  = 33'd1 << 7;
  localparam logic [32:0] LOI  = 33'd1 << 6;
  localparam logic [32:0] HIO  = 33'd1 << 5;
  localparam logic [32:0] LOO  = 33'd1 << 4;
  localparam logic [32:0] INPO = 33'd1 << 3;
  localparam logic [32:0] OUTP = 33'd1 << 2;
  localparam logic [32:0] CO   = 33'd1 << 1;
  localparam logic [32:0] CONI = 33'd1 << 0;

  control_unit dut (
    .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .Run(Run), .operation(operation),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin),
    .LOin(LOin), .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
    .OutPortin(OutPortin), .Cout(Cout), .CONin(CONin)
  );

  assign obs = {Run, operation, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin,
                IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin,
                Zhighout, Zlowout, HIin, LOin, HIout, LOout, InPortout,
                OutPortin, Cout, CONin};

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [32:0] opf(input logic [4:0] o);
    return {1'b0, o, 27'd0};
  endfunction

  // Build the full expected step list for one instruction into seq.
  task automatic build(input logic [31:0] ir, input logic con);
    logic [4:0] op;
    op = ir[31:27];
    seq.delete();
    seq.push_back(RUN | PCO | MARI | INC | ZI);
    seq.push_back(RUN | ZLO | PCI | RD | MDRI);
    seq.push_back(RUN | MDRO | IRI);
    if (op >= 5'd3 && op <= 5'd11) begin
      seq.push_back(RUN | GRB | ROUT | YI);
      seq.push_back(RUN | GRC | ROUT | ZI | opf(op));
      seq.push_back(RUN | ZLO | GRA | RIN);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      seq.push_back(RUN | GRB | ROUT | YI);
      seq.push_back(RUN | CO | ZI | opf(op));
      seq.push_back(RUN | ZLO | GRA | RIN);
    end else if (op == 5'd1) begin
      seq.push_back(RUN | GRB | BAO | YI);
      seq.push_back(RUN | CO | ZI | opf(5'd3));
      seq.push_back(RUN | ZLO | GRA | RIN);
    end else if (op == 5'd0 || op == 5'd2) begin
      seq.push_back(RUN | GRB | BAO | YI);
      seq.push_back(RUN | CO | ZI | opf(5'd3));
      seq.push_back(RUN | ZLO | MARI);
      if (op == 5'd0) begin
        seq.push_back(RUN | RD | MDRI);
        seq.push_back(RUN | MDRO | GRA | RIN);
      end else begin
        seq.push_back(RUN | GRA | ROUT | MDRI);
        seq.push_back(RUN | WR);
      end
    end else if (op == 5'd15 || op == 5'd16) begin
      seq.push_back(RUN | GRA | ROUT | YI);
      seq.push_back(RUN | GRB | ROUT | ZI | opf(op));
      seq.push_back(RUN | ZLO | LOI);
      seq.push_back(RUN | ZHO | HII);
    end else if (op == 5'd17 || op == 5'd18) begin
      seq.push_back(RUN | GRB | ROUT | ZI | opf(op));
      seq.push_back(RUN | ZLO | GRA | RIN);
    end else if (op == 5'd19) begin
      seq.push_back(RUN | GRA | ROUT | CONI);
      seq.push_back(RUN | PCO | YI);
      seq.push_back(RUN | CO | ZI | opf(5'd3));
      seq.push_back(RUN | ZLO | (con ? PCI : 33'd0));
    end else if (op == 5'd20) begin
      seq.push_back(RUN | GRA | ROUT | PCI);
    end else if (op == 5'd22) begin
      seq.push_back(RUN | INPO | GRA | RIN);
    end else if (op == 5'd23) begin
      seq.push_back(RUN | GRA | ROUT | OUTP);
    end else if (op == 5'd24) begin
      seq.push_back(RUN | HIO | GRA | RIN);
    end else if (op == 5'd25) begin
      seq.push_back(RUN | LOO | GRA | RIN);
    end
  endtask

  task automatic check(input string tag);
    logic [32:0] e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // Run the first k steps of an instruction starting at the next T0;
  // Stop is held high for one cycle after step stop_at is checked.
  task automatic run_instr(input string name, input logic [31:0] ir,
                           input logic con, input int k, input int stop_at);
    build(ir, con);
    for (int i = 0; i < k && i < seq.size(); i++) sb.push_back(seq[i]);
    @(posedge Clock);
    #1;
    IR = ir;
    CON_FF = con;
    for (int i = 0; i < k && i < seq.size(); i++) begin
      @(negedge Clock);
      check($sformatf("%s T%0d", name, i));
      Stop = (i == stop_at);
    end
    Stop = 1'b0;
  endtask

  task automatic idle_zero(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(33'd0);
      @(negedge Clock);
      check($sformatf("%s idle%0d", name, i));
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge Clock);
    clear = 1'b0;
    #1;
    sb.push_back(33'd0);
    check({name, " async"});
    idle_zero(name, 2);
    clear = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    sb.push_back(33'd0);
    check("reset state");
    clear = 1'b1;

    run_instr("add",   32'h18918000, 1'b0, 99, -1);
    run_instr("ld",    32'h00800000, 1'b0, 99, -1);
    run_instr("st",    32'h10800000, 1'b0, 99, -1);
    run_instr("br0",   32'h98000000, 1'b0, 99, -1);
    run_instr("br1",   32'h98000000, 1'b1, 99, -1);
    run_instr("mul",   32'h80000000, 1'b0, 99, -1);
    run_instr("undef", 32'hF8000000, 1'b0, 99, -1);
    run_instr("div",   32'h78000000, 1'b0, 99, -1);
    run_instr("neg",   32'h88000000, 1'b0, 99, -1);
    run_instr("not",   32'h90000000, 1'b0, 99, -1);
    run_instr("jr",    32'hA0000000, 1'b0, 99, -1);
    run_instr("in",    32'hB0000000, 1'b0, 99, -1);
    run_instr("out",   32'hB8000000, 1'b0, 99, -1);
    run_instr("mfhi",  32'hC0000000, 1'b0, 99, -1);
    run_instr("mflo",  32'hC8000000, 1'b0, 99, -1);
    run_instr("addi",  32'h60000000, 1'b0, 99, -1);
    run_instr("ori",   32'h70000000, 1'b0, 99, -1);
    run_instr("ldi",   32'h08000000, 1'b0, 99, -1);
    run_instr("ror",   32'h40000000, 1'b0, 99, -1);
    run_instr("nop",   32'hD0000000, 1'b0, 99, -1);
    run_instr("undf5", 32'hA8000000, 1'b0, 99, -1);

    // clear asserted mid-T4 of add: outputs drop with no clock edge
    run_instr("add_mid", 32'h18918000, 1'b0, 5, -1);
    #2;
    clear = 1'b0;
    #1;
    sb.push_back(33'd0);
    check("clear mid-op async");
    @(negedge Clock);
    sb.push_back(33'd0);
    check("clear mid-op held");
    clear = 1'b1;
    run_instr("add_after", 32'h18918000, 1'b0, 99, -1);

    // Stop pulse during T4: T5 finishes, then HALT instead of T0
    run_instr("add_stop", 32'h18918000, 1'b0, 99, 4);
    idle_zero("stop_halt", 6);

    do_reset("reset2");
    run_instr("halt", 32'hD8000000, 1'b0, 99, -1);
    idle_zero("halt", 20);

    do_reset("reset3");
    run_instr("post_halt_add", 32'h18918000, 1'b0, 99, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
